// File: rtl/race_power_meter.sv
// Block-average power monitor for the RACE filter complex output stream.
// Optional per-block peak tracking is enabled by defining RACE_PWR_PEAK_HOLD_EN.
module race_power_meter #(
    parameter int DW     = 16,
    parameter int LOG2_N = 6,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 strobe,
    input  logic                 valid_in,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    input  logic                 clear,
    output logic [2*DW-1:0]      power_out,
    output logic                 power_valid,
    output logic [CNT_W-1:0]     block_cnt,
    output logic [2*DW-1:0]      peak_out
);

    localparam int AW = 2*DW + LOG2_N;

    // A sample is taken only on a rising strobe edge with valid_in high; there is
    // no backpressure. power_valid is a single-cycle pulse marking a new power_out.
    logic strobe_d;
    logic sample_en;

    assign sample_en = strobe & ~strobe_d & valid_in;

    logic signed [2*DW-1:0] re_x, im_x, prod_r, prod_i;

    assign re_x   = (2*DW)'(in_real);
    assign im_x   = (2*DW)'(in_imag);
    assign prod_r = re_x * re_x;
    assign prod_i = im_x * im_x;

    logic [2*DW-1:0] sq_r, sq_i;
    logic            s1_valid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            strobe_d <= 1'b1;
            s1_valid <= 1'b0;
            sq_r     <= '0;
            sq_i     <= '0;
        end else begin
            strobe_d <= strobe;
            s1_valid <= sample_en & ~clear;
            if (sample_en) begin
                sq_r <= $unsigned(prod_r);
                sq_i <= $unsigned(prod_i);
            end
        end
    end

    // Each square is at most 2^(2DW-2), so the sum fits in 2*DW bits.
    logic [2*DW-1:0]   p;
    logic [LOG2_N-1:0] cnt;
    logic [AW-1:0]     acc, acc_next;
    logic              last;

    assign p        = sq_r + sq_i;
    assign last     = &cnt;
    assign acc_next = ((cnt == '0) ? '0 : acc) + AW'(p);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt         <= '0;
            acc         <= '0;
            power_out   <= '0;
            power_valid <= 1'b0;
            block_cnt   <= '0;
        end else begin
            power_valid <= 1'b0;
            if (clear) begin
                cnt <= '0;
                acc <= '0;
            end else if (s1_valid) begin
                if (last) begin
                    power_out   <= acc_next[AW-1:LOG2_N];
                    power_valid <= 1'b1;
                    block_cnt   <= block_cnt + CNT_W'(1);
                    cnt         <= '0;
                    acc         <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + LOG2_N'(1);
                end
            end
        end
    end

`ifdef RACE_PWR_PEAK_HOLD_EN
    logic [2*DW-1:0] blk_peak;
    logic [2*DW-1:0] peak_next;

    // The first sample of a block replaces whatever peak was left over.
    assign peak_next = ((cnt == '0) || (p > blk_peak)) ? p : blk_peak;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            blk_peak <= '0;
            peak_out <= '0;
        end else begin
            if (clear) begin
                blk_peak <= '0;
            end else if (s1_valid) begin
                if (last) begin
                    peak_out <= peak_next;
                    blk_peak <= '0;
                end else begin
                    blk_peak <= peak_next;
                end
            end
        end
    end
`else
    assign peak_out = '0;
`endif

endmodule

// File: tb/tb_race_power_meter.sv
// Bench for race_power_meter: directed block scenarios plus random samples,
// compared every cycle against a queue-based block-average model.
module tb_race_power_meter;

    localparam int DW     = 16;
    localparam int LOG2_N = 2;
    localparam int CNT_W  = 16;
    localparam int N      = 1 << LOG2_N;

    logic                 clk = 1'b0;
    logic                 nrst = 1'b1;
    logic                 strobe = 1'b0;
    logic                 valid_in = 1'b0;
    logic                 clear = 1'b0;
    logic signed [DW-1:0] in_real = '0;
    logic signed [DW-1:0] in_imag = '0;
    logic [2*DW-1:0]      power_out;
    logic                 power_valid;
    logic [CNT_W-1:0]     block_cnt;
    logic [2*DW-1:0]      peak_out;

    int errors = 0;
    int checks = 0;
    int div_cnt = 10;
    int pv_count = 0;

    race_power_meter #(.DW(DW), .LOG2_N(LOG2_N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .strobe     (strobe),
        .valid_in   (valid_in),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .clear      (clear),
        .power_out  (power_out),
        .power_valid(power_valid),
        .block_cnt  (block_cnt),
        .peak_out   (peak_out)
    );

    // ---------------- clock / reset / divide-by-20 strobe ----------------
    always #5 clk = ~clk;

    always @(posedge clk) div_cnt <= (div_cnt == 19) ? 0 : div_cnt + 1;
    always @(negedge clk) strobe = (div_cnt < 10);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2*DW-1:0]  blk_q[$];
    bit               s1_pend = 1'b0;
    logic [2*DW-1:0]  s1_pow = '0;
    bit               prev_strobe = 1'b1;
    logic [2*DW-1:0]  exp_power = '0;
    logic [2*DW-1:0]  exp_peak = '0;
    logic             exp_pv = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            blk_q.delete();
            s1_pend     = 1'b0;
            exp_power   = '0;
            exp_peak    = '0;
            exp_pv      = 1'b0;
            exp_cnt     = '0;
            prev_strobe = 1'b1;
        end else begin
            exp_pv = 1'b0;
            if (s1_pend && !clear) begin
                blk_q.push_back(s1_pow);
                if (blk_q.size() == N) begin
                    longint unsigned sum;
                    logic [2*DW-1:0] mx;
                    sum = 0;
                    mx  = '0;
                    foreach (blk_q[i]) begin
                        sum += longint'(blk_q[i]);
                        if (blk_q[i] > mx) mx = blk_q[i];
                    end
                    exp_power = (2*DW)'(sum >> LOG2_N);
                    exp_pv    = 1'b1;
                    exp_cnt   = exp_cnt + CNT_W'(1);
`ifdef RACE_PWR_PEAK_HOLD_EN
                    exp_peak  = mx;
`endif
                    blk_q.delete();
                end
            end
            if (clear) blk_q.delete();
            s1_pend     = strobe && !prev_strobe && valid_in && !clear;
            s1_pow      = (2*DW)'(longint'(in_real) * longint'(in_real) +
                                  longint'(in_imag) * longint'(in_imag));
            prev_strobe = strobe;
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (power_valid === 1'b1) pv_count++;
        check("power_valid", 64'(power_valid), 64'(exp_pv));
        check("power_out",   64'(power_out),   64'(exp_power));
        check("block_cnt",   64'(block_cnt),   64'(exp_cnt));
        check("peak_out",    64'(peak_out),    64'(exp_peak));
    end

    // ---------------- driver tasks ----------------
    // Inputs change in the strobe low phase; clear fires in the cycle whose
    // div_cnt equals clr_at (0 = accepting cycle, 1 = the cycle after it).
    task automatic send(input int re, input int im, input bit v, input int clr_at);
        do @(negedge clk); while (div_cnt != 15);
        in_real  = DW'(re);
        in_imag  = DW'(im);
        valid_in = v;
        clear    = (clr_at == 15);
        do begin
            @(negedge clk);
            clear = (div_cnt == clr_at);
        end while (div_cnt != 5);
        clear = 1'b0;
    endtask

    task automatic send_n(input int re, input int im, input int n);
        for (int i = 0; i < n; i++) send(re, im, 1'b1, -1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("rst_power_out",   64'(power_out),   64'd0);
        check("rst_power_valid", 64'(power_valid), 64'd0);
        check("rst_block_cnt",   64'(block_cnt),   64'd0);
        check("rst_peak_out",    64'(peak_out),    64'd0);
        repeat (3) @(negedge clk);
        #2 nrst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pv0;
        #1 nrst = 1'b0;
        repeat (4) @(negedge clk);
        #2 nrst = 1'b1;
        check("reset_power_out", 64'(power_out), 64'd0);
        check("reset_block_cnt", 64'(block_cnt), 64'd0);

        // constant 1000 + j0: three blocks
        pv0 = pv_count;
        for (int b = 1; b <= 3; b++) begin
            send_n(1000, 0, N);
            check("const_power", 64'(power_out), 64'd1000000);
            check("const_blkcnt", 64'(block_cnt), 64'(b));
        end
        check("const_pulses", 64'(pv_count - pv0), 64'd3);

        // full-scale corners
        send_n(-32768, -32768, N);
        check("neg_fullscale", 64'(power_out), 64'h8000_0000);
        send_n(32767, 32767, N);
        check("pos_fullscale", 64'(power_out), 64'h7FFE_0002);

        // valid gaps do not split a block
        pv0 = pv_count;
        send(100, 0, 1'b1, -1);
        send(200, 0, 1'b1, -1);
        send(0, 0, 1'b0, -1);
        send(0, 0, 1'b0, -1);
        send(300, 0, 1'b1, -1);
        send(400, 0, 1'b1, -1);
        check("gap_power", 64'(power_out), 64'd75000);
        check("gap_pulses", 64'(pv_count - pv0), 64'd1);
        check("gap_blkcnt", 64'(block_cnt), 64'd6);

        // clear flushes a partial block
        pv0 = pv_count;
        send_n(1000, 0, 2);
        send(0, 0, 1'b0, 17);
        send_n(10, 0, N);
        check("clear_power", 64'(power_out), 64'd100);
        check("clear_pulses", 64'(pv_count - pv0), 64'd1);

        // clear coinciding with the accepting cycle and with the stage after it
        pv0 = pv_count;
        send_n(7, 0, 2);
        send(500, 0, 1'b1, 0);
        send(500, 0, 1'b1, 1);
        send_n(7, 0, N);
        check("clear_edge_power", 64'(power_out), 64'd49);
        check("clear_edge_pulses", 64'(pv_count - pv0), 64'd1);

        // reset in the middle of a block
        send_n(5, 0, 3);
        do_reset();
        send_n(5, 0, N);
        check("post_rst_power", 64'(power_out), 64'd25);
        check("post_rst_blkcnt", 64'(block_cnt), 64'd1);

        // peak hold
        send(3, 4, 1'b1, -1);
        send(1, 0, 1'b1, -1);
        send(0, 2, 1'b1, -1);
        send(0, 0, 1'b1, -1);
        check("peak_blk_power", 64'(power_out), 64'd7);
`ifdef RACE_PWR_PEAK_HOLD_EN
        check("peak_value", 64'(peak_out), 64'd25);
`else
        check("peak_value", 64'(peak_out), 64'd0);
`endif

        // random samples, gaps and clears
        for (int i = 0; i < 80; i++) begin
            int r, clr_at;
            r = int'($urandom_range(0, 11));
            clr_at = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 17 : -1;
            send(int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768,
                 ($urandom_range(0, 3) != 0), clr_at);
        end

        repeat (25) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
